filter_seq_ctrl: RTL and testbench

Stimulus sequencer for the emulated analog filter. It drives the filter's fixed-point `v_in` through a programmed list of up to DEPTH levels and holds each level for a programmed number of emulator cycles. At the end of each hold it captures the filter's `v_out` and hands the sample to a downstream consumer over a valid/ready handshake. It sits between the host-side configuration/capture logic and the filter instance, replacing the constant `v_in` drive used in plain step tests.

---
 rtl/filter_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_filter_seq_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_seq_ctrl.sv
// Stimulus sequencer for the emulated analog filter: plays a table of levels on v_in,
// holds each for a programmed count, captures v_out and offers it over valid/ready.
module filter_seq_ctrl #(
    parameter int WIDTH     = 18,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 emu_clk,
    input  logic                 emu_rst_n,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [WIDTH-1:0]     cfg_level,
    input  logic [CNT_WIDTH-1:0] cfg_hold,
    input  logic [AW:0]          cfg_num,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     v_in,
    input  logic [WIDTH-1:0]     v_out,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic [WIDTH-1:0]     sample_data,
    output logic [AW-1:0]        sample_idx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [WIDTH-1:0]     level_mem [DEPTH];
    logic [CNT_WIDTH-1:0] hold_mem  [DEPTH];

    logic [2:0]           state_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [AW-1:0]        idx_reg;
    logic [AW:0]          num_reg;
    logic [WIDTH-1:0]     v_in_reg;
    logic [WIDTH-1:0]     sample_data_reg;
    logic [AW-1:0]        sample_idx_reg;

    logic [AW:0]          num_clamped;
    logic [CNT_WIDTH-1:0] hold_eff;
    logic                 last_entry;

    // Table is plain storage with no reset so a host-loaded program survives emulator resets.
    always_ff @(posedge emu_clk) begin
        if (cfg_we && !busy) begin
            level_mem[cfg_addr] <= cfg_level;
            hold_mem[cfg_addr]  <= cfg_hold;
        end
    end

    assign num_clamped = (cfg_num > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_num;
    assign hold_eff    = (hold_mem[idx_reg] == '0) ? CNT_WIDTH'(1) : hold_mem[idx_reg];
    assign last_entry  = ({1'b0, idx_reg} == (num_reg - (AW+1)'(1)));

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            num_reg         <= '0;
            v_in_reg        <= '0;
            sample_data_reg <= '0;
            sample_idx_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_num != '0) begin
                            num_reg   <= num_clamped;
                            idx_reg   <= '0;
                            state_reg <= S_LOAD;
                        end else begin
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_reg <= S_DONE;
                    end else begin
                        v_in_reg  <= level_mem[idx_reg];
                        cnt_reg   <= hold_eff;
                        state_reg <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Capture on the last hold cycle so v_out reflects exactly H cycles of drive.
                    if (abort) begin
                        state_reg <= S_DONE;
                    end else if (cnt_reg == CNT_WIDTH'(1)) begin
                        sample_data_reg <= v_out;
                        sample_idx_reg  <= idx_reg;
                        state_reg       <= S_SAMPLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_WIDTH'(1);
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        state_reg <= S_DONE;
                    end else if (sample_ready) begin
                        if (last_entry) begin
                            state_reg <= S_DONE;
                        end else begin
                            idx_reg   <= idx_reg + AW'(1);
                            state_reg <= S_LOAD;
                        end
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign v_in         = v_in_reg;
    assign sample_data  = sample_data_reg;
    assign sample_idx   = sample_idx_reg;
    assign sample_valid = (state_reg == S_SAMPLE);
    assign busy         = (state_reg != S_IDLE);
    assign done         = (state_reg == S_DONE);

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Directed and randomized checks of filter_seq_ctrl against a transaction-level
// schedule model (level/hold table, per-entry period, back-pressure, abort, reset).
module tb_filter_seq_ctrl;

    localparam int W     = 18;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int AW    = 3;

    logic          emu_clk = 1'b0;
    logic          emu_rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [W-1:0]  cfg_level = '0;
    logic [CW-1:0] cfg_hold = '0;
    logic [AW:0]   cfg_num = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  v_in;
    logic [W-1:0]  v_out = '0;
    logic          sample_valid;
    logic          sample_ready = 1'b0;
    logic [W-1:0]  sample_data;
    logic [AW-1:0] sample_idx;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int tick_cnt = 0;

    logic [W-1:0]  lvl [DEPTH];
    logic [CW-1:0] hld [DEPTH];
    logic [W-1:0]  exp_vin;

    filter_seq_ctrl #(.WIDTH(W), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .emu_clk(emu_clk), .emu_rst_n(emu_rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_level(cfg_level), .cfg_hold(cfg_hold),
        .cfg_num(cfg_num), .start(start), .abort(abort),
        .v_in(v_in), .v_out(v_out),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_data(sample_data), .sample_idx(sample_idx),
        .busy(busy), .done(done)
    );

    always #5 emu_clk = ~emu_clk;

    task automatic tick();
        @(posedge emu_clk);
        #1;
        tick_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [W-1:0] lv, input logic [CW-1:0] h);
        cfg_we = 1'b1; cfg_addr = a[AW-1:0]; cfg_level = lv; cfg_hold = h;
        tick();
        cfg_we = 1'b0;
        lvl[a] = lv;
        hld[a] = h;
    endtask

    // Plays one sequence and checks it cycle by cycle against the schedule implied by the table.
    task automatic play(input int n_req, input int bp_e, input int bp_n,
                        input int ab_e, input int rst_e, input bit guard);
        int n, t0, exp_t, hh, w;
        bit accepted;
        logic [W-1:0] last_r;
        n = (n_req > DEPTH) ? DEPTH : n_req;
        exp_t = 1;
        for (int e = 0; e < n; e++) exp_t += ((hld[e] == 0) ? 1 : int'(hld[e])) + 2;
        if (bp_e >= 0 && bp_e < n) exp_t += bp_n;
        $display("play: num=%0d bp_entry=%0d bp_cycles=%0d abort_entry=%0d reset_entry=%0d guard=%0d",
                 n_req, bp_e, bp_n, ab_e, rst_e, guard);
        chk("pre_busy", 32'(busy), 32'd0);
        t0 = tick_cnt;
        cfg_num = n_req[AW:0]; start = 1'b1;
        tick();
        start = 1'b0;
        if (n == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_busy", 32'(busy), 32'd1);
            chk("zero_valid", 32'(sample_valid), 32'd0);
            chk("zero_vin", 32'(v_in), 32'(exp_vin));
            tick();
            chk("zero_idle_done", 32'(done), 32'd0);
            chk("zero_idle_busy", 32'(busy), 32'd0);
            return;
        end
        for (int e = 0; e < n; e++) begin
            chk("load_busy", 32'(busy), 32'd1);
            chk("load_valid", 32'(sample_valid), 32'd0);
            chk("load_done", 32'(done), 32'd0);
            chk("load_vin_prev", 32'(v_in), 32'(exp_vin));
            if (guard && e == 0) begin
                cfg_we = 1'b1; cfg_addr = AW'(1); cfg_level = ~lvl[1]; cfg_hold = hld[1] + CW'(3);
                start = 1'b1;
            end
            tick();
            cfg_we = 1'b0; start = 1'b0;
            exp_vin = lvl[e];
            hh = (hld[e] == 0) ? 1 : int'(hld[e]);
            last_r = '0;
            for (int k = 0; k < hh; k++) begin
                chk("hold_vin", 32'(v_in), 32'(lvl[e]));
                chk("hold_valid", 32'(sample_valid), 32'd0);
                v_out = W'($urandom);
                last_r = v_out;
                if (e == rst_e && k == 0) begin
                    #2 emu_rst_n = 1'b0;
                    #1;
                    chk("rst_vin", 32'(v_in), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_valid", 32'(sample_valid), 32'd0);
                    chk("rst_data", 32'(sample_data), 32'd0);
                    chk("rst_idx", 32'(sample_idx), 32'd0);
                    chk("rst_done", 32'(done), 32'd0);
                    tick();
                    emu_rst_n = 1'b1;
                    exp_vin = '0;
                    tick();
                    chk("rst_idle_busy", 32'(busy), 32'd0);
                    return;
                end
                tick();
            end
            w = 0;
            accepted = 1'b0;
            while (!accepted) begin
                chk("samp_valid", 32'(sample_valid), 32'd1);
                chk("samp_data", 32'(sample_data), 32'(last_r));
                chk("samp_idx", 32'(sample_idx), 32'(e));
                chk("samp_vin", 32'(v_in), 32'(lvl[e]));
                if (e == ab_e && w == 1) begin
                    abort = 1'b1; sample_ready = 1'b0;
                    tick();
                    abort = 1'b0;
                    chk("ab_valid", 32'(sample_valid), 32'd0);
                    chk("ab_done", 32'(done), 32'd1);
                    chk("ab_vin", 32'(v_in), 32'(lvl[e]));
                    tick();
                    chk("ab_busy", 32'(busy), 32'd0);
                    chk("ab_done_end", 32'(done), 32'd0);
                    chk("ab_vin_after", 32'(v_in), 32'(lvl[e]));
                    return;
                end
                if (e == ab_e) sample_ready = 1'b0;
                else if (e == bp_e && w < bp_n) sample_ready = 1'b0;
                else sample_ready = 1'b1;
                accepted = sample_ready;
                v_out = W'($urandom);
                tick();
                w++;
            end
            sample_ready = 1'b0;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_valid", 32'(sample_valid), 32'd0);
        chk("done_cycles", 32'(tick_cnt - t0), 32'(exp_t));
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_vin", 32'(v_in), 32'(lvl[n-1]));
        chk("idle_total", 32'(tick_cnt - t0), 32'(exp_t + 1));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            lvl[i] = '0;
            hld[i] = '0;
        end
        exp_vin = '0;
        tick();
        tick();
        chk("reset_vin", 32'(v_in), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(sample_valid), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_data", 32'(sample_data), 32'd0);
        chk("reset_idx", 32'(sample_idx), 32'd0);
        emu_rst_n = 1'b1;
        tick();

        // Table fully defined before any play (it is not cleared by reset).
        for (int a = 0; a < DEPTH; a++) wr(a, W'(a * 1000), CW'(2));

        // Single step: 1.0 (14 fractional bits), hold 100.
        wr(0, W'(16384), CW'(100));
        play(1, -1, 0, -1, -1, 1'b0);

        // Staircase 0.5, -0.5, 1.25 with holds 3, 0, 5 and four cycles of back-pressure.
        wr(0, W'(8192), CW'(3));
        wr(1, W'(-8192), CW'(0));
        wr(2, W'(20480), CW'(5));
        play(3, 0, 4, -1, -1, 1'b0);

        // Abort while entry 1 waits in SAMPLE with ready low.
        play(3, -1, 0, 1, -1, 1'b0);

        // Writes and start while busy are ignored; replay proves the table is intact.
        play(3, -1, 0, -1, -1, 1'b1);
        play(3, 1, 2, -1, -1, 1'b0);

        // Empty sequence.
        play(0, -1, 0, -1, -1, 1'b0);

        // Asynchronous reset during entry 1 HOLD, then replay from entry 0.
        play(3, -1, 0, -1, 1, 1'b0);
        play(3, -1, 0, -1, -1, 1'b0);

        // Randomized tables: full depth, clamped depth, then random lengths.
        for (int r = 0; r < 5; r++) begin
            int n_req;
            for (int a = 0; a < DEPTH; a++) wr(a, W'($urandom), CW'($urandom_range(0, 6)));
            n_req = (r == 0) ? DEPTH : (r == 1) ? DEPTH + 1 : int'($urandom_range(1, DEPTH));
            play(n_req, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)), -1, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
